sync_fifo_flags: RTL

Parametrised synchronous FIFO with independent read and write enables, simultaneous read/write, an occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the next-generation single-clock buffer used between producer and consumer stages in the FIFO verification environment. It replaces the single-enable write-or-read FIFO, whose direction is chosen by `en`.

---
 rtl/sync_fifo_flags.sv | 116 +++++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with simultaneous read/write, registered occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_flags #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AFULL_TH   = 12,
    parameter int unsigned AEMPTY_TH  = 4,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned ADDR_W    = PTR_W - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic wr_accept;
    logic rd_accept;

    // Flags decode from the registered count only, never from the enables.
    assign full         = (count_q == PTR_W'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= PTR_W'(AFULL_TH));
    assign almost_empty = (count_q <= PTR_W'(AEMPTY_TH));

    assign count     = count_q;
    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;

        // A full FIFO still takes a write when a read frees a slot this edge.
        rd_accept = rd_en && !empty;
        wr_accept = wr_en && (!full || rd_en);

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            data_out_d = mem[rd_ptr_q[ADDR_W-1:0]];
            rd_valid_d = 1'b1;
        end

        if (wr_accept && !rd_accept) begin
            count_d = count_q + PTR_W'(1);
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - PTR_W'(1);
        end

        // A new error in the same cycle as clr_err keeps the flag set.
        overflow_d  = (overflow_q && !clr_err) || (wr_en && !wr_accept);
        underflow_d = (underflow_q && !clr_err) || (rd_en && !rd_accept);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage has no reset; its contents are unreachable until rewritten,
    // and leaving it out lets the array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= data_in;
        end
    end

endmodule
